// File: rtl/dct_coef_feeder.sv
// dct_coef_feeder: accepts one log filter-bank energy per beat and presents it,
// together with that bin's row of NUM_COEF DCT basis coefficients, to the
// downstream multiplier/accumulator bank. Tracks the bin position within a
// frame, marks the frame end and raises a sticky flag on framing errors.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tdata_in        input energy sample
//   tvalid_in       input valid
//   tlast_in        input marks last bin of frame
//   tready_out      block can accept input this cycle (combinational)
//   tready_in       downstream ready
//   data_to_mult_a  registered copy of the accepted sample
//   data_to_mult_b  coefficient row, lane k at [k*COEF_W +: COEF_W]
//   mult_bin        bin index of presented beat
//   mult_valid      output beat valid
//   mult_last       presented beat is the last bin of the frame
//   frame_err       sticky framing error flag
//   err_clr         clears frame_err
//   coef_wr_en      coefficient row write strobe
//   coef_wr_addr    row to write (out-of-range addresses are ignored)
//   coef_wr_data    full coefficient row
module dct_coef_feeder #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NUM_COEF  = 13,
  parameter int unsigned FRAME_LEN = 26,
  parameter int unsigned BIN_W     = $clog2(FRAME_LEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          tdata_in,
  input  logic                       tvalid_in,
  input  logic                       tlast_in,
  output logic                       tready_out,
  input  logic                       tready_in,
  output logic [DATA_W-1:0]          data_to_mult_a,
  output logic [NUM_COEF*COEF_W-1:0] data_to_mult_b,
  output logic [BIN_W-1:0]           mult_bin,
  output logic                       mult_valid,
  output logic                       mult_last,
  output logic                       frame_err,
  input  logic                       err_clr,
  input  logic                       coef_wr_en,
  input  logic [BIN_W-1:0]           coef_wr_addr,
  input  logic [NUM_COEF*COEF_W-1:0] coef_wr_data
);

  localparam int unsigned ROW_W = NUM_COEF * COEF_W;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {IDLE, IN_FRAME} state_t;

  state_t             state;
  logic [BIN_W-1:0]   bin_cnt;
  logic               rst_done;
  logic [ROW_W-1:0]   coef_mem [FRAME_LEN];

  logic               accept;
  logic               at_last;
  logic               bin_err;
  logic               addr_ok;
  logic [BIN_W-1:0]   bin_next;

  // rst_done keeps ready low until the first cycle after reset is released
  assign tready_out = rst_done && (!mult_valid || tready_in);
  assign accept     = tvalid_in && tready_out;
  assign at_last    = (bin_cnt == LAST_BIN);
  // early last or missing last: either way the counter resyncs to bin 0
  assign bin_err    = (tlast_in != at_last);
  assign bin_next   = (tlast_in || at_last) ? '0 : bin_cnt + BIN_W'(1);
  assign addr_ok    = ({1'b0, coef_wr_addr} < (BIN_W + 1)'(FRAME_LEN));

  // Coefficient table: not reset; NBA write gives read-before-write on collision
  always_ff @(posedge clk) begin
    if (!rst && coef_wr_en && addr_ok) begin
      coef_mem[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Output register, bin counter, frame state and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bin_cnt        <= '0;
      rst_done       <= 1'b0;
      mult_valid     <= 1'b0;
      mult_last      <= 1'b0;
      mult_bin       <= '0;
      data_to_mult_a <= '0;
      data_to_mult_b <= '0;
      frame_err      <= 1'b0;
    end else begin
      rst_done <= 1'b1;

      if (accept) begin
        mult_valid     <= 1'b1;
        data_to_mult_a <= tdata_in;
        data_to_mult_b <= coef_mem[bin_cnt];
        mult_bin       <= bin_cnt;
        mult_last      <= at_last;
        bin_cnt        <= bin_next;
      end else if (tready_in) begin
        mult_valid <= 1'b0;
      end

      case (state)
        IDLE:     if (accept && (bin_cnt == '0) && !tlast_in) state <= IN_FRAME;
        IN_FRAME: if (accept && (at_last || tlast_in))        state <= IDLE;
        default:  state <= IDLE;
      endcase

      // a new error outranks a simultaneous clear
      if (accept && bin_err) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_coef_feeder.sv
module tb_dct_coef_feeder;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned NUM_COEF  = 13;
  localparam int unsigned FRAME_LEN = 26;
  localparam int unsigned BIN_W     = 5;
  localparam int unsigned ROW_W     = NUM_COEF * COEF_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] tdata_in;
  logic              tvalid_in;
  logic              tlast_in;
  logic              tready_out;
  logic              tready_in;
  logic [DATA_W-1:0] data_to_mult_a;
  logic [ROW_W-1:0]  data_to_mult_b;
  logic [BIN_W-1:0]  mult_bin;
  logic              mult_valid;
  logic              mult_last;
  logic              frame_err;
  logic              err_clr;
  logic              coef_wr_en;
  logic [BIN_W-1:0]  coef_wr_addr;
  logic [ROW_W-1:0]  coef_wr_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [ROW_W-1:0] exp_mem [FRAME_LEN];

  always #5 clk = ~clk;

  dct_coef_feeder #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_COEF(NUM_COEF),
    .FRAME_LEN(FRAME_LEN), .BIN_W(BIN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .tdata_in(tdata_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
    .tready_out(tready_out), .tready_in(tready_in),
    .data_to_mult_a(data_to_mult_a), .data_to_mult_b(data_to_mult_b),
    .mult_bin(mult_bin), .mult_valid(mult_valid), .mult_last(mult_last),
    .frame_err(frame_err), .err_clr(err_clr),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data)
  );

  function automatic logic [ROW_W-1:0] row_of(int b);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < int'(NUM_COEF); k++) r[k*COEF_W +: COEF_W] = 16'(b * 16 + k);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] fill_row(logic [15:0] v);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < int'(NUM_COEF); k++) r[k*COEF_W +: COEF_W] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tvalid_in = 1'b0; tlast_in = 1'b0; tdata_in = '0; tready_in = 1'b1;
    err_clr = 1'b0; coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    repeat (3) tick();
    n_chk++;
    if (tready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", tready_out); end
    rst = 1'b0;
    tick();
    n_chk++;
    if (mult_valid !== 1'b0 || frame_err !== 1'b0 || mult_last !== 1'b0 || mult_bin !== '0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b err=%b last=%b bin=%0d want 0", mult_valid, frame_err, mult_last, mult_bin);
    end
    n_chk++;
    if (data_to_mult_a !== '0 || data_to_mult_b !== '0) begin
      n_fail++; $display("FAIL reset_data: a=%h b=%h want 0", data_to_mult_a, data_to_mult_b);
    end
    n_chk++;
    if (tready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", tready_out); end
  endtask

  task automatic load_table();
    for (int b = 0; b < int'(FRAME_LEN); b++) begin
      coef_wr_en = 1'b1; coef_wr_addr = BIN_W'(b); coef_wr_data = row_of(b);
      exp_mem[b] = row_of(b);
      tick();
    end
    coef_wr_en = 1'b0;
  endtask

  task automatic test_full_frame();
    tready_in = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      tvalid_in = 1'b1; tdata_in = 16'(n); tlast_in = (n == 26);
      tick();
      n_chk++;
      if (mult_valid !== 1'b1 || data_to_mult_a !== 16'(n) || mult_bin !== BIN_W'(n - 1) ||
          mult_last !== (n == 26) || data_to_mult_b !== exp_mem[n-1]) begin
        n_fail++;
        $display("FAIL full_beat%0d: valid=%b a=%0d bin=%0d last=%b b=%h want 1 %0d %0d %b %h",
                 n, mult_valid, data_to_mult_a, mult_bin, mult_last, data_to_mult_b,
                 n, n - 1, (n == 26), exp_mem[n-1]);
      end
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    tick();
    n_chk++;
    if (mult_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL full_end: valid=%b err=%b want 0 0", mult_valid, frame_err);
    end
  endtask

  task automatic test_backpressure();
    tready_in = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      tvalid_in = 1'b1; tdata_in = 16'(100 + n); tlast_in = (n == 26);
      tick();
      n_chk++;
      if (mult_valid !== 1'b1 || data_to_mult_a !== 16'(100 + n) || mult_bin !== BIN_W'(n - 1) ||
          mult_last !== (n == 26) || data_to_mult_b !== exp_mem[n-1]) begin
        n_fail++;
        $display("FAIL bp_beat%0d: valid=%b a=%0d bin=%0d last=%b want 1 %0d %0d %b",
                 n, mult_valid, data_to_mult_a, mult_bin, mult_last, 100 + n, n - 1, (n == 26));
      end
      if (n == 8) begin
        // stall with beat 9 already offered
        tready_in = 1'b0; tdata_in = 16'(109); tlast_in = 1'b0;
        for (int s = 0; s < 4; s++) begin
          tick();
          n_chk++;
          if (tready_out !== 1'b0 || mult_valid !== 1'b1 || data_to_mult_a !== 16'(108) ||
              mult_bin !== BIN_W'(7) || data_to_mult_b !== exp_mem[7]) begin
            n_fail++;
            $display("FAIL bp_stall%0d: rdy=%b valid=%b a=%0d bin=%0d want 0 1 108 7",
                     s, tready_out, mult_valid, data_to_mult_a, mult_bin);
          end
        end
        tready_in = 1'b1;
      end
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    tick();
    n_chk++;
    if (mult_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL bp_end: valid=%b err=%b want 0 0", mult_valid, frame_err);
    end
  endtask

  task automatic test_frame_err();
    tready_in = 1'b1;
    // early last on beat 10 (bin 9)
    for (int n = 1; n <= 10; n++) begin
      tvalid_in = 1'b1; tdata_in = 16'(200 + n); tlast_in = (n == 10);
      tick();
    end
    n_chk++;
    if (frame_err !== 1'b1 || mult_bin !== BIN_W'(9) || mult_last !== 1'b0) begin
      n_fail++; $display("FAIL early_last: err=%b bin=%0d last=%b want 1 9 0", frame_err, mult_bin, mult_last);
    end
    // resynced stream: bins 0..25, no tlast on bin 25
    for (int b = 0; b < 26; b++) begin
      tvalid_in = 1'b1; tdata_in = 16'(300 + b); tlast_in = 1'b0;
      tick();
      if (b == 0) begin
        n_chk++;
        if (mult_bin !== BIN_W'(0) || data_to_mult_a !== 16'(300)) begin
          n_fail++; $display("FAIL resync_bin: bin=%0d a=%0d want 0 300", mult_bin, data_to_mult_a);
        end
      end
    end
    n_chk++;
    if (frame_err !== 1'b1 || mult_bin !== BIN_W'(25) || mult_last !== 1'b1 || data_to_mult_a !== 16'(325)) begin
      n_fail++; $display("FAIL missing_last: err=%b bin=%0d last=%b a=%0d want 1 25 1 325",
                         frame_err, mult_bin, mult_last, data_to_mult_a);
    end
    tvalid_in = 1'b0; err_clr = 1'b1;
    tick();
    n_chk++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", frame_err); end
    // clear together with a new early last at bin 0
    tvalid_in = 1'b1; tdata_in = 16'(400); tlast_in = 1'b1; err_clr = 1'b1;
    tick();
    n_chk++;
    if (frame_err !== 1'b1 || mult_bin !== BIN_W'(0) || mult_last !== 1'b0) begin
      n_fail++; $display("FAIL err_vs_clr: err=%b bin=%0d last=%b want 1 0 0", frame_err, mult_bin, mult_last);
    end
    tvalid_in = 1'b0; tlast_in = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++;
    if (frame_err !== 1'b0 || mult_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_final_clr: err=%b valid=%b want 0 0", frame_err, mult_valid);
    end
  endtask

  task automatic test_coef_collision();
    tready_in = 1'b1;
    for (int b = 0; b < 26; b++) begin
      tvalid_in = 1'b1; tdata_in = 16'(500 + b); tlast_in = (b == 25);
      coef_wr_en = (b == 5); coef_wr_addr = BIN_W'(5); coef_wr_data = fill_row(16'hAAAA);
      tick();
      coef_wr_en = 1'b0;
      if (b == 5) begin
        n_chk++;
        if (data_to_mult_b !== row_of(5) || mult_bin !== BIN_W'(5)) begin
          n_fail++; $display("FAIL collision_old: b=%h bin=%0d want %h 5", data_to_mult_b, mult_bin, row_of(5));
        end
        exp_mem[5] = fill_row(16'hAAAA);
      end
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    // out-of-range writes must leave the table untouched
    coef_wr_en = 1'b1; coef_wr_addr = BIN_W'(26); coef_wr_data = fill_row(16'h5555);
    tick();
    coef_wr_addr = BIN_W'(31);
    tick();
    coef_wr_en = 1'b0;
    for (int b = 0; b < 26; b++) begin
      tvalid_in = 1'b1; tdata_in = 16'(600 + b); tlast_in = (b == 25);
      tick();
      n_chk++;
      if (data_to_mult_b !== exp_mem[b] || mult_bin !== BIN_W'(b)) begin
        n_fail++; $display("FAIL table_row%0d: b=%h bin=%0d want %h %0d", b, data_to_mult_b, mult_bin, exp_mem[b], b);
      end
    end
    tvalid_in = 1'b0; tlast_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    tready_in = 1'b1;
    for (int b = 0; b <= 12; b++) begin
      tvalid_in = 1'b1; tdata_in = 16'(700 + b); tlast_in = 1'b0;
      tick();
    end
    n_chk++;
    if (mult_valid !== 1'b1 || mult_bin !== BIN_W'(12)) begin
      n_fail++; $display("FAIL mid_pre: valid=%b bin=%0d want 1 12", mult_valid, mult_bin);
    end
    rst = 1'b1; tdata_in = 16'(999);
    coef_wr_en = 1'b1; coef_wr_addr = BIN_W'(0); coef_wr_data = fill_row(16'h1234);
    tick();
    coef_wr_en = 1'b0;
    n_chk++;
    if (mult_valid !== 1'b0 || frame_err !== 1'b0 || mult_bin !== '0) begin
      n_fail++; $display("FAIL mid_rst: valid=%b err=%b bin=%0d want 0 0 0", mult_valid, frame_err, mult_bin);
    end
    rst = 1'b0; tvalid_in = 1'b0;
    tick();
    for (int b = 0; b < 6; b++) begin
      tvalid_in = 1'b1; tdata_in = 16'(800 + b); tlast_in = 1'b0;
      tick();
      n_chk++;
      if (mult_valid !== 1'b1 || mult_bin !== BIN_W'(b) || data_to_mult_a !== 16'(800 + b) ||
          data_to_mult_b !== exp_mem[b]) begin
        n_fail++; $display("FAIL post_rst_bin%0d: valid=%b bin=%0d a=%0d b=%h want 1 %0d %0d %h",
                           b, mult_valid, mult_bin, data_to_mult_a, data_to_mult_b, b, 800 + b, exp_mem[b]);
      end
    end
    tvalid_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    load_table();
    test_full_frame();
    test_backpressure();
    test_frame_err();
    test_coef_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
